// File: rtl/timer_pkg.sv
// Shared timer-family definitions: division select codes, mode codes and
// the prescale mask helper used by the prescaler, the timer core and models.
package timer_pkg;

  localparam int CKS_DIV2  = 0;
  localparam int CKS_DIV4  = 1;
  localparam int CKS_DIV8  = 2;
  localparam int CKS_DIV16 = 3;

  localparam logic MODE_INT = 1'b0;
  localparam logic MODE_EXT = 1'b1;

  // Terminal count for a select code: period 2^(cks+1), so mask = 2^(cks+1)-1.
  function automatic logic [31:0] cks_mask(input logic [31:0] cks);
    return (32'd2 << cks) - 32'd1;
  endfunction

endpackage

// File: rtl/pclk_sync2.sv
// Two-flop synchroniser into the pclk domain, async active-low reset.
module pclk_sync2 #(
  parameter int W = 1
) (
  input  logic         pclk,
  input  logic         preset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/timer_prescaler.sv
// Clock-enable prescaler: single-cycle tick every 2^(cks+1) enabled pclk edges,
// or on each synchronised ext_clk rise. Select/mode changes land only at period ends.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int CKS_W = 2,
  parameter int DIV_W = 4
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CKS_W-1:0] cks,
  input  logic             ext_sel,
  input  logic             ext_clk,
  output logic             tick,
  output logic [CKS_W-1:0] cks_active,
  output logic             ext_active,
  output logic [DIV_W-1:0] div_cnt
);

  if (DIV_W < (1 << CKS_W)) begin : g_bad_width
    $error("timer_prescaler: DIV_W must be >= 2**CKS_W");
  end

  logic             ext_s;
  logic             ext_h;
  logic             ext_rise;
  logic [DIV_W-1:0] mask;

  pclk_sync2 #(.W(1)) u_ext_sync (
    .pclk     (pclk),
    .preset_n (preset_n),
    .d        (ext_clk),
    .q        (ext_s)
  );

  // Edge history runs regardless of en so an edge seen while disabled is consumed.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) ext_h <= 1'b0;
    else           ext_h <= ext_s;
  end

  assign ext_rise = ext_s & ~ext_h;
  assign mask     = DIV_W'(cks_mask(32'(cks_active)));

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      div_cnt    <= '0;
      tick       <= 1'b0;
      cks_active <= '0;
      ext_active <= MODE_INT;
    end else if (clr) begin
      div_cnt    <= '0;
      tick       <= 1'b0;
      cks_active <= cks;
      ext_active <= ext_sel;
    end else if (!en) begin
      tick <= 1'b0;
    end else if (ext_active == MODE_EXT) begin
      div_cnt <= '0;
      tick    <= ext_rise;
      if (ext_rise) begin
        cks_active <= cks;
        ext_active <= ext_sel;
      end
    end else if (div_cnt == mask) begin
      div_cnt    <= '0;
      tick       <= 1'b1;
      cks_active <= cks;
      ext_active <= ext_sel;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_prescaler.sv
// Randomised bench for timer_prescaler against a period/event-level reference model.
module tb_timer_prescaler;
  localparam int CKS_W = 2;
  localparam int DIV_W = 4;

  logic             pclk = 1'b0;
  logic             preset_n = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic [CKS_W-1:0] cks = '0;
  logic             ext_sel = 1'b0;
  logic             ext_clk = 1'b0;
  logic             tick;
  logic [CKS_W-1:0] cks_active;
  logic             ext_active;
  logic [DIV_W-1:0] div_cnt;

  timer_prescaler #(.CKS_W(CKS_W), .DIV_W(DIV_W)) dut (
    .pclk       (pclk),
    .preset_n   (preset_n),
    .en         (en),
    .clr        (clr),
    .cks        (cks),
    .ext_sel    (ext_sel),
    .ext_clk    (ext_clk),
    .tick       (tick),
    .cks_active (cks_active),
    .ext_active (ext_active),
    .div_cnt    (div_cnt)
  );

  always #5 pclk = ~pclk;

  int n_chk = 0;
  int n_bad = 0;

  // Reference state: position within period, select/mode in force, tick, ext sample history.
  int m_pos, m_cks, m_ext, m_tick;
  int ext_hist[$];
  int ext_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_cks = 0; m_ext = 0; m_tick = 0;
    ext_hist = '{0, 0, 0};
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".tick"},       32'(tick),       32'(m_tick));
    chk({ph, ".div_cnt"},    32'(div_cnt),    32'(m_pos));
    chk({ph, ".cks_active"}, 32'(cks_active), 32'(m_cks));
    chk({ph, ".ext_active"}, 32'(ext_active), 32'(m_ext));
  endtask

  // Advance the model by one pclk edge using the inputs now applied, then compare.
  task automatic step(input string ph);
    int rise;
    ext_hist.push_back(int'(ext_clk));
    // An edge is seen two samples late (two sync stages) against the sample before it.
    rise = (ext_hist[1] == 1 && ext_hist[0] == 0) ? 1 : 0;
    void'(ext_hist.pop_front());
    if (clr) begin
      m_pos = 0; m_tick = 0; m_cks = int'(cks); m_ext = int'(ext_sel);
    end else if (!en) begin
      m_tick = 0;
    end else if (m_ext == 1) begin
      m_pos = 0; m_tick = rise;
      if (rise == 1) begin m_cks = int'(cks); m_ext = int'(ext_sel); end
    end else if (m_pos + 1 == (2 << m_cks)) begin
      m_pos = 0; m_tick = 1; m_cks = int'(cks); m_ext = int'(ext_sel);
    end else begin
      m_pos++; m_tick = 0;
    end
    @(posedge pclk);
    @(negedge pclk);
    check_all(ph);
  endtask

  task automatic drive_ext();
    if (ext_left == 0) begin
      ext_clk  = ~ext_clk;
      ext_left = $urandom_range(2, 5);
    end
    ext_left--;
  endtask

  int en_pct[6]  = '{100, 90, 100, 70, 95, 85};
  int clr_pct[6] = '{0,   2,  4,   3,  5,  3};
  int cks_pct[6] = '{0,   10, 30,  5,  20, 50};
  int ext_pct[6] = '{0,   0,  50,  50, 30, 50};

  initial begin
    model_reset();
    ext_left = 3;
    @(negedge pclk);
    check_all("reset");
    @(negedge pclk);
    check_all("reset_hold");
    preset_n = 1'b1;
    en = 1'b1;
    // Directed: divide-by-2 from reset, then a mid-period select change to /16 then /4.
    for (int i = 0; i < 8; i++) step("div2");
    cks = 2'd3;
    for (int i = 0; i < 6; i++) step("to_div16");
    cks = 2'd1;
    for (int i = 0; i < 24; i++) step("div16_to_4");

    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 400; c++) begin
        en  = ($urandom_range(0, 99) < en_pct[p]);
        clr = ($urandom_range(0, 99) < clr_pct[p]);
        if ($urandom_range(0, 99) < cks_pct[p]) cks = CKS_W'($urandom_range(0, 3));
        ext_sel = ($urandom_range(0, 99) < ext_pct[p]);
        drive_ext();
        if (p == 3 && c == 200) begin
          // Asynchronous reset mid-period: outputs clear without waiting for an edge.
          preset_n = 1'b0;
          #1;
          model_reset();
          check_all("async_rst");
          @(negedge pclk);
          check_all("rst_held");
          preset_n = 1'b1;
        end
        step($sformatf("ph%0d", p));
      end
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
